// File: rtl/serial_tx_if.sv
// Handshake and line signals of the parallel-to-serial transmitter.
// The master drives the word and start request; the slave (transmitter) drives the line and status.
interface serial_tx_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data;
  logic             start;
  logic             q;
  logic             busy;
  logic             done;

  modport master (
    output data,
    output start,
    input  q,
    input  busy,
    input  done
  );

  modport slave (
    input  data,
    input  start,
    output q,
    output busy,
    output done
  );
endinterface

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit 0, WIDTH data bits LSB first, stop bit 1,
// each bit held DIV clocks. All outputs come straight from flops so the line is glitch-free.
module serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic      clk,
  input  logic      rst,
  serial_tx_if.slave tx
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] cnt_last = CW'(DIV - 1);
  localparam logic [IW-1:0] idx_last = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_start = 2'd1,
    st_data  = 2'd2,
    st_stop  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [IW-1:0]    idx_r, idx_s;
  logic             q_r, q_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             period_end_s;

  // Next-state, datapath and next-output decode
  always_comb begin
    state_s      = state_r;
    shreg_s      = shreg_r;
    cnt_s        = cnt_r;
    idx_s        = idx_r;
    done_s       = 1'b0;
    q_s          = 1'b1;
    busy_s       = 1'b0;
    period_end_s = (cnt_r == cnt_last);

    case (state_r)
      st_idle: begin
        if (tx.start) begin
          state_s = st_start;
          shreg_s = tx.data;
          cnt_s   = {CW{1'b0}};
          idx_s   = {IW{1'b0}};
        end else begin
          state_s = st_idle;
        end
      end
      st_start: begin
        if (period_end_s) begin
          state_s = st_data;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      st_data: begin
        if (period_end_s) begin
          cnt_s   = {CW{1'b0}};
          shreg_s = shreg_r >> 1;
          if (idx_r == idx_last) begin
            state_s = st_stop;
          end else begin
            idx_s = idx_r + IW'(1);
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      st_stop: begin
        if (period_end_s) begin
          state_s = st_idle;
          cnt_s   = {CW{1'b0}};
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = st_idle;
        cnt_s   = {CW{1'b0}};
        idx_s   = {IW{1'b0}};
      end
    endcase

    // Outputs are decoded from the next state so they appear one edge after acceptance
    case (state_s)
      st_idle: begin
        q_s    = 1'b1;
        busy_s = 1'b0;
      end
      st_start: begin
        q_s    = 1'b0;
        busy_s = 1'b1;
      end
      st_data: begin
        q_s    = shreg_s[0];
        busy_s = 1'b1;
      end
      st_stop: begin
        q_s    = 1'b1;
        busy_s = 1'b1;
      end
      default: begin
        q_s    = 1'b1;
        busy_s = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= st_idle;
      shreg_r <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      idx_r   <= {IW{1'b0}};
      q_r     <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      q_r     <= q_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign tx.q    = q_r;
  assign tx.busy = busy_r;
  assign tx.done = done_r;
endmodule

// File: tb/tb_serial_tx.sv
// Directed and randomized checks of serial_tx at DIV=4 and DIV=1 (WIDTH=8),
// comparing the line against a frame model built from {stop, data, start} bits.
module tb_serial_tx;
  logic clk;
  logic rst;
  logic clk_run;
  int   checks;
  int   errors;
  int   cyc;
  int   done_cyc;

  serial_tx_if #(.WIDTH(8)) if4 ();
  serial_tx_if #(.WIDTH(8)) if1 ();

  serial_tx #(.WIDTH(8), .DIV(4)) u_div4 (.clk(clk), .rst(rst), .tx(if4));
  serial_tx #(.WIDTH(8), .DIV(1)) u_div1 (.clk(clk), .rst(rst), .tx(if1));

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input int div, input logic st, input logic [7:0] d);
    if (div == 1) begin
      if1.start = st;
      if1.data  = d;
    end else begin
      if4.start = st;
      if4.data  = d;
    end
  endtask

  task automatic check_outs(input int div, input string tag, input logic eq, input logic eb,
                            input logic ed);
    logic qo, bo, dn;
    if (div == 1) begin
      qo = if1.q; bo = if1.busy; dn = if1.done;
    end else begin
      qo = if4.q; bo = if4.busy; dn = if4.done;
    end
    check({tag, ".q"}, {31'd0, qo}, {31'd0, eq});
    check({tag, ".busy"}, {31'd0, bo}, {31'd0, eb});
    check({tag, ".done"}, {31'd0, dn}, {31'd0, ed});
  endtask

  // Starts a frame at the current cycle and follows it to the done cycle.
  // ign_at: cycle of the frame at which a rejected start/0xFF is pulsed (-1 none).
  // abort_at: cycle of the frame at which reset is asserted between edges (-1 none).
  task automatic send_frame(input int div, input logic [7:0] d, input int ign_at,
                            input int abort_at);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    drive(div, 1'b1, d);
    tick();
    drive(div, 1'b0, 8'($urandom));
    for (int t = 0; t < 10 * div; t++) begin
      check_outs(div, "frame", fr[t / div], 1'b1, 1'b0);
      if (t == abort_at) begin
        #2;
        rst = 1'b1;
        #1;
        check_outs(div, "abort", 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        return;
      end
      if (t == ign_at) begin
        drive(div, 1'b1, 8'hFF);
      end else begin
        drive(div, 1'b0, 8'($urandom));
      end
      tick();
    end
    check_outs(div, "done", 1'b1, 1'b0, 1'b1);
    done_cyc = cyc;
  endtask

  initial begin
    int d1;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    done_cyc = 0;
    clk_run  = 1'b0;
    rst      = 1'b0;
    drive(4, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);

    // Reset with no clock running
    #1 rst = 1'b1;
    #1;
    check_outs(4, "rst4", 1'b1, 1'b0, 1'b0);
    check_outs(1, "rst1", 1'b1, 1'b0, 1'b0);
    clk_run = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_outs(4, "idle4", 1'b1, 1'b0, 1'b0);
      check_outs(1, "idle1", 1'b1, 1'b0, 1'b0);
    end

    // Single frame 0xA5
    send_frame(4, 8'hA5, -1, -1);
    tick();
    check_outs(4, "after_a5", 1'b1, 1'b0, 1'b0);

    // Start while busy is ignored, exactly one done
    send_frame(4, 8'h3C, 10, -1);
    tick();
    check_outs(4, "after_3c", 1'b1, 1'b0, 1'b0);
    repeat (3) tick();

    // Back-to-back: second start in the done cycle
    send_frame(4, 8'h01, -1, -1);
    d1 = done_cyc;
    send_frame(4, 8'h80, -1, -1);
    check("done_spacing", 32'(done_cyc - d1), 32'd41);
    tick();
    check_outs(4, "after_b2b", 1'b1, 1'b0, 1'b0);

    // Reset mid-frame, then a clean frame
    send_frame(4, 8'h55, -1, 17);
    repeat (2) begin
      check_outs(4, "post_abort", 1'b1, 1'b0, 1'b0);
      tick();
    end
    send_frame(4, 8'hF0, -1, -1);
    tick();

    // DIV=1 frames
    send_frame(1, 8'h00, -1, -1);
    tick();
    check_outs(1, "after_00", 1'b1, 1'b0, 1'b0);
    send_frame(1, 8'hFF, -1, -1);
    tick();
    check_outs(1, "after_ff", 1'b1, 1'b0, 1'b0);

    // Randomized frames with random rejected starts, sometimes back-to-back
    for (int i = 0; i < 12; i++) begin
      int div;
      div = (i % 2 == 0) ? 4 : 1;
      send_frame(div, 8'($urandom), int'($urandom_range(0, 10 * div - 3)), -1);
      if ($urandom_range(0, 1) == 0) begin
        tick();
        check_outs(div, "rnd_idle", 1'b1, 1'b0, 1'b0);
      end
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
